// File: rtl/uart_chk_pkg.sv
// uart_chk_pkg: shared FSM encoding and parity-type constants for the UART frame checker
package uart_chk_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/exp_fifo.sv
// exp_fifo: expected-payload FIFO with registered full/empty and extra-bit wrap pointers
module exp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wnext, rnext;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wnext   = wptr + {{AW{1'b0}}, do_push};
  assign rnext   = rptr + {{AW{1'b0}}, do_pop};
  assign dout    = mem[rptr[AW-1:0]];
  // pointer and flag registers; flags derive from the next pointers so they stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wnext;
      rptr  <= rnext;
      full  <= (wnext[AW] != rnext[AW]) && (wnext[AW-1:0] == rnext[AW-1:0]);
      empty <= wnext == rnext;
    end
  end
  // storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_frame_checker.sv
// uart_frame_checker: samples one serial bit per clock, checks frames against expected data
module uart_frame_checker
  import uart_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_vld,
  output logic                  exp_rdy,
  input  logic                  clr_cnt,
  output logic                  frame_done,
  output logic                  frame_pass,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  no_exp,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, head;
  logic par_en_q, par_typ_q, par_err_p, stp_err_p;
  logic fifo_full, fifo_empty;
  logic data_last, stop_last, frame_end, stp_bad, par_exp, pass_nx;
  assign data_last = bit_cnt == BW'(DATA_WIDTH - 1);
  assign stop_last = bit_cnt == BW'(STOP_BITS - 1);
  assign frame_end = state == STOP && stop_last;
  assign stp_bad   = stp_err_p | ~ser_in;
  assign par_exp   = (par_typ_q == PAR_ODD) ? ~^shreg : ^shreg;
  assign pass_nx   = !fifo_empty && head == shreg && !par_err_p && !stp_bad;
  assign exp_rdy   = ~fifo_full;
  exp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (exp_vld),
    .pop   (frame_end),
    .din   (exp_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: start bit, payload, optional parity, stop bits
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = ser_in ? IDLE : DATA;
      DATA:    state_nx = data_last ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_nx = STOP;
      STOP:    state_nx = stop_last ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  // frame datapath: shift register, bit counter, pending errors and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_p  <= 1'b0;
      stp_err_p  <= 1'b0;
      frame_done <= 1'b0;
      frame_pass <= 1'b0;
      rx_data    <= '0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      no_exp     <= 1'b0;
    end else begin
      if (state == IDLE && !ser_in) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        bit_cnt   <= '0;
        par_err_p <= 1'b0;
        stp_err_p <= 1'b0;
      end
      if (state == DATA) begin
        shreg   <= {ser_in, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
      end
      if (state == PARITY && ser_in != par_exp) par_err_p <= 1'b1;
      if (state == STOP) begin
        bit_cnt <= stop_last ? '0 : bit_cnt + 1'b1;
        if (!ser_in) stp_err_p <= 1'b1;
      end
      frame_done <= frame_end;
      if (frame_end) begin
        rx_data    <= shreg;
        frame_pass <= pass_nx;
        par_err    <= par_err_p;
        stp_err    <= stp_bad;
        no_exp     <= fifo_empty;
      end
    end
  end
  // saturating pass/fail counters; clear wins over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr_cnt) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (frame_end) begin
      if (pass_nx) pass_cnt <= &pass_cnt ? pass_cnt : pass_cnt + 1'b1;
      else fail_cnt <= &fail_cnt ? fail_cnt : fail_cnt + 1'b1;
    end
  end
endmodule
